// File: rtl/intersection_traffic_model.sv
// -----------------------------------------------------------------------------
// intersection_traffic_model
//
// Closed-loop model of a five-lane intersection. It sits opposite a
// traffic_light_controller: it takes the controller's lights and drives the
// controller's sensor inputs. Each lane keeps a car queue. Cars arrive on
// one-cycle pulses and depart while the lane is green. A lane's sensor is high
// while its queue is non-empty. The model also watches the light inputs for
// unsafe combinations, illegal colour codes and lanes starved at red.
//
// Lane order everywhere: 0 e_left, 1 e_str, 2 w_left, 3 w_str, 4 ns.
// Colour encoding: red=0, yellow=1, green=2, 3 is illegal.
//
// Ports
//   clk              system clock, all state on the rising edge
//   reset            asynchronous, active-high; clears all state and queues
//   *_light [1:0]    colour of each lane's signal head
//   arrive [4:0]     one-car arrival pulse per lane, sampled every clk
//   *_sensor         queue of that lane is non-empty
//   q_count          flattened queue counts, lane i at [i*QW +: QW]
//   depart [4:0]     registered one-cycle pulse per departed car
//   total_departed   cumulative departures, wraps mod 2^16
//   overflow         sticky: an arrival was dropped at a full queue
//   conflict         sticky: an unsafe light combination was seen
//   conflict_code    lowest rule number of the first conflict, 0 if none
//   bad_color        sticky: some light input was the illegal code 3
//   starve [4:0]     sticky per-lane starvation flags
// -----------------------------------------------------------------------------
module intersection_traffic_model #(
    parameter int QW         = 4,
    parameter int STARVE_LIM = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      e_left_light,
    input  logic [1:0]      e_str_light,
    input  logic [1:0]      w_left_light,
    input  logic [1:0]      w_str_light,
    input  logic [1:0]      ns_light,
    input  logic [4:0]      arrive,
    output logic            e_left_sensor,
    output logic            e_str_sensor,
    output logic            w_left_sensor,
    output logic            w_str_sensor,
    output logic            ns_sensor,
    output logic [5*QW-1:0] q_count,
    output logic [4:0]      depart,
    output logic [15:0]     total_departed,
    output logic            overflow,
    output logic            conflict,
    output logic [2:0]      conflict_code,
    output logic            bad_color,
    output logic [4:0]      starve
);

    localparam logic [1:0]    RED     = 2'd0;
    localparam logic [1:0]    GREEN   = 2'd2;
    localparam logic [1:0]    ILLEGAL = 2'd3;
    localparam logic [QW-1:0] MAXQ    = '1;
    localparam logic [7:0]    LIM     = 8'(STARVE_LIM);

    // State
    logic [QW-1:0] q        [5];
    logic [7:0]    wait_cnt [5];
    logic [4:0]    green_d;

    // Next-state and decode
    logic [1:0]    light     [5];
    logic [QW-1:0] q_next    [5];
    logic [7:0]    wait_next [5];
    logic [4:0]    dep;
    logic [2:0]    dep_cnt;
    logic          ovf_hit;
    logic [4:0]    starve_hit;
    logic [4:0]    non_red;
    logic [3:0]    rule;        // rule[k] is conflict rule k+1
    logic [2:0]    first_rule;
    logic          any_illegal;

    always_comb begin
        light[0] = e_left_light;
        light[1] = e_str_light;
        light[2] = w_left_light;
        light[3] = w_str_light;
        light[4] = ns_light;
    end

    // Queue, departure and starvation next-state.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        dep        = '0;
        dep_cnt    = '0;
        ovf_hit    = 1'b0;
        starve_hit = '0;
        for (int i = 0; i < 5; i++) begin
            q_next[i]    = q[i];
            wait_next[i] = '0;
        end

        for (int i = 0; i < 5; i++) begin
            // green_d adds a one-cycle reaction time: the first car leaves
            // on the second consecutive green cycle.
            dep[i] = (light[i] == GREEN) && green_d[i] && (q[i] != '0);

            if (arrive[i] && !dep[i]) begin
                if (q[i] == MAXQ) ovf_hit = 1'b1;
                else              q_next[i] = q[i] + 1'b1;
            end else if (!arrive[i] && dep[i]) begin
                q_next[i] = q[i] - 1'b1;
            end
            // arrive together with dep leaves the count unchanged.

            dep_cnt = dep_cnt + {2'b00, dep[i]};

            // Only a truly red head counts as waiting; yellow, green and the
            // illegal code all clear the counter.
            if ((q[i] != '0) && (light[i] == RED))
                wait_next[i] = (wait_cnt[i] >= LIM) ? LIM : wait_cnt[i] + 8'd1;

            starve_hit[i] = (wait_next[i] == LIM);
        end
    end

    // Light safety. The illegal code is not red, so it counts as showing.
    always_comb begin
        any_illegal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            non_red[i] = (light[i] != RED);
            if (light[i] == ILLEGAL) any_illegal = 1'b1;
        end
        rule[0] = non_red[0] && (non_red[3] || non_red[4]);
        rule[1] = non_red[2] && (non_red[1] || non_red[4]);
        rule[2] = non_red[1] && non_red[4];
        rule[3] = non_red[3] && non_red[4];

        first_rule = 3'd0;
        if      (rule[0]) first_rule = 3'd1;
        else if (rule[1]) first_rule = 3'd2;
        else if (rule[2]) first_rule = 3'd3;
        else if (rule[3]) first_rule = 3'd4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the queue and counter arrays are reset element by element;
            // a reset must discard waiting cars, so these cannot be left as
            // uninitialised storage.
            for (int i = 0; i < 5; i++) begin
                q[i]        <= '0;
                wait_cnt[i] <= '0;
            end
            green_d        <= '0;
            depart         <= '0;
            total_departed <= '0;
            overflow       <= 1'b0;
            conflict       <= 1'b0;
            conflict_code  <= 3'd0;
            bad_color      <= 1'b0;
            starve         <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge value of its inputs regardless of order.
            for (int i = 0; i < 5; i++) begin
                q[i]        <= q_next[i];
                wait_cnt[i] <= wait_next[i];
                green_d[i]  <= (light[i] == GREEN);
            end
            depart         <= dep;
            total_departed <= total_departed + 16'(dep_cnt);
            if (ovf_hit)     overflow  <= 1'b1;
            if (any_illegal) bad_color <= 1'b1;
            starve         <= starve | starve_hit;
            // The first conflict is frozen; later ones do not touch the code.
            if (!conflict && (first_rule != 3'd0)) begin
                conflict      <= 1'b1;
                conflict_code <= first_rule;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) q_count[i*QW +: QW] = q[i];
    end

    assign e_left_sensor = (q[0] != '0);
    assign e_str_sensor  = (q[1] != '0);
    assign w_left_sensor = (q[2] != '0);
    assign w_str_sensor  = (q[3] != '0);
    assign ns_sensor     = (q[4] != '0);

endmodule

// File: tb/tb_intersection_traffic_model.sv
// -----------------------------------------------------------------------------
// Self-checking bench for intersection_traffic_model. Each scenario task drives
// stimulus, pushes the expected post-edge state onto a scoreboard queue, then
// pops it after the edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_intersection_traffic_model;

    localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2, BAD = 2'd3;

    logic        clk;
    logic        reset;
    logic [1:0]  lt [5];
    logic [4:0]  arrive;
    logic        e_left_sensor, e_str_sensor, w_left_sensor, w_str_sensor, ns_sensor;
    logic [19:0] q_count;
    logic [4:0]  depart;
    logic [15:0] total_departed;
    logic        overflow, conflict, bad_color;
    logic [2:0]  conflict_code;
    logic [4:0]  starve;

    intersection_traffic_model #(.QW(4), .STARVE_LIM(20)) dut (
        .clk           (clk),
        .reset         (reset),
        .e_left_light  (lt[0]),
        .e_str_light   (lt[1]),
        .w_left_light  (lt[2]),
        .w_str_light   (lt[3]),
        .ns_light      (lt[4]),
        .arrive        (arrive),
        .e_left_sensor (e_left_sensor),
        .e_str_sensor  (e_str_sensor),
        .w_left_sensor (w_left_sensor),
        .w_str_sensor  (w_str_sensor),
        .ns_sensor     (ns_sensor),
        .q_count       (q_count),
        .depart        (depart),
        .total_departed(total_departed),
        .overflow      (overflow),
        .conflict      (conflict),
        .conflict_code (conflict_code),
        .bad_color     (bad_color),
        .starve        (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  sens_v;
    logic [10:0] flags_v;
    assign sens_v  = {ns_sensor, w_str_sensor, w_left_sensor, e_str_sensor, e_left_sensor};
    assign flags_v = {overflow, conflict, conflict_code, bad_color, starve};

    typedef struct {
        string       tag;
        logic [19:0] q;
        logic [4:0]  sens;
        logic [4:0]  dep;
        logic [15:0] tot;
        logic [10:0] flags;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    // Expected state as the test plan dictates it.
    int          e_q [5];
    logic [15:0] e_tot;
    logic        e_ovf, e_conf, e_bad;
    logic [2:0]  e_code;
    logic [4:0]  e_starve;

    function automatic exp_t snap(input string tag, input logic [4:0] dep);
        exp_t e;
        e.tag = tag;
        for (int i = 0; i < 5; i++) begin
            e.q[i*4 +: 4] = 4'(e_q[i]);
            e.sens[i]     = (e_q[i] != 0);
        end
        e.dep   = dep;
        e.tot   = e_tot;
        e.flags = {e_ovf, e_conf, e_code, e_bad, e_starve};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        arrive = '0;
        for (int i = 0; i < 5; i++) begin
            lt[i]  = RED;
            e_q[i] = 0;
        end
        e_tot = '0; e_ovf = 1'b0; e_conf = 1'b0; e_bad = 1'b0;
        e_code = 3'd0; e_starve = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        arrive = 5'b11111;          // arrivals must be ignored while in reset
        for (int i = 0; i < 5; i++) lt[i] = GREEN;
        for (int i = 0; i < 5; i++) e_q[i] = 0;
        e_tot = '0; e_ovf = 1'b0; e_conf = 1'b0; e_bad = 1'b0;
        e_code = 3'd0; e_starve = '0;
        sb.push_back(snap("reset", 5'b0));
        tick(); tick();
        e = sb.pop_front();
        checks++;
        if ({q_count, sens_v, depart, total_departed, flags_v} !==
            {e.q, e.sens, e.dep, e.tot, e.flags}) begin
            failures++;
            $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                     e.tag, q_count, sens_v, depart, total_departed, flags_v,
                     e.q, e.sens, e.dep, e.tot, e.flags);
        end
        do_reset();
    endtask

    // Three arrivals on lane 0 at red, then lane 0 green drains them.
    task automatic test_arrival_and_departure();
        exp_t e;
        int   qs [5] = '{3, 2, 1, 0, 0};
        logic [4:0] d;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            arrive = (k <= 3) ? 5'b00001 : 5'b00000;
            e_q[0] = (k <= 3) ? k : 3;
            sb.push_back(snap($sformatf("arrive_%0d", k), 5'b0));
            tick();
            arrive = '0;
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
        end
        lt[0] = GREEN;
        for (int i = 0; i < 5; i++) begin
            d = (i >= 1 && i <= 3) ? 5'b00001 : 5'b00000;
            e_q[0] = qs[i];
            if (d != 0) e_tot = e_tot + 16'd1;
            sb.push_back(snap($sformatf("drain_T+%0d", i), d));
            tick();
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
        end
        lt[0] = RED;
    endtask

    // Lane 4 holds 2 cars; one arrives every green cycle after the reaction
    // cycle, so the count stays at 2 while a car departs every cycle.
    task automatic test_back_to_back();
        exp_t e;
        logic [4:0] d;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) lt[4] = GREEN;
            if (i == 7) lt[4] = RED;
            arrive = (i < 2 || (i >= 3 && i <= 6)) ? 5'b10000 : 5'b00000;
            e_q[4] = (i == 0) ? 1 : 2;
            d = (i >= 3 && i <= 6) ? 5'b10000 : 5'b00000;
            if (d != 0) e_tot = e_tot + 16'd1;
            sb.push_back(snap($sformatf("steady_%0d", i), d));
            tick();
            arrive = '0;
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
        end
    endtask

    // 16 arrivals fill lane 1 to 15 and drop one; overflow outlives the drain.
    task automatic test_overflow();
        exp_t e;
        logic [4:0] d;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            arrive = 5'b00010;
            e_q[1] = (k < 15) ? k : 15;
            if (k == 16) e_ovf = 1'b1;
            sb.push_back(snap($sformatf("fill_%0d", k), 5'b0));
            tick();
            arrive = '0;
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
        end
        lt[1] = GREEN;
        for (int i = 0; i <= 16; i++) begin
            d = (i >= 1 && i <= 15) ? 5'b00010 : 5'b00000;
            e_q[1] = (i == 0) ? 15 : ((i <= 15) ? 15 - i : 0);
            if (d != 0) e_tot = e_tot + 16'd1;
            sb.push_back(snap($sformatf("empty_%0d", i), d));
            tick();
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
        end
        lt[1] = RED;
    endtask

    // Each row: light pattern, reset first?, and the expected sticky flags.
    typedef struct {
        logic       rst;
        logic [1:0] l0, l1, l2, l3, l4;
        logic       conf;
        logic [2:0] code;
        logic       bad;
    } conf_row_t;

    task automatic test_conflict();
        exp_t e;
        conf_row_t rows [7];
        rows[0] = '{1'b1, RED,   RED,   RED, RED,   RED,    1'b0, 3'd0, 1'b0};
        rows[1] = '{1'b0, RED,   GREEN, RED, GREEN, RED,    1'b0, 3'd0, 1'b0}; // legal pair
        rows[2] = '{1'b0, RED,   GREEN, RED, RED,   YELLOW, 1'b1, 3'd3, 1'b0}; // rule 3
        rows[3] = '{1'b0, GREEN, RED,   RED, RED,   GREEN,  1'b1, 3'd3, 1'b0}; // rule 1, frozen
        rows[4] = '{1'b0, RED,   RED,   BAD, RED,   RED,    1'b1, 3'd3, 1'b1}; // illegal colour
        rows[5] = '{1'b1, GREEN, GREEN, RED, RED,   GREEN,  1'b1, 3'd1, 1'b0}; // rules 1+3 -> 1
        rows[6] = '{1'b1, RED,   RED,   RED, BAD,   GREEN,  1'b1, 3'd4, 1'b1}; // illegal as non-red
        for (int r = 0; r < 7; r++) begin
            if (rows[r].rst) do_reset();
            lt[0] = rows[r].l0; lt[1] = rows[r].l1; lt[2] = rows[r].l2;
            lt[3] = rows[r].l3; lt[4] = rows[r].l4;
            e_conf = rows[r].conf; e_code = rows[r].code; e_bad = rows[r].bad;
            sb.push_back(snap($sformatf("conflict_row%0d", r), 5'b0));
            tick();
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
        end
        do_reset();
    endtask

    // Lane 3 holds one car at red: starve[3] sets on the 20th waiting cycle.
    // A one-cycle green at cycle 10 restarts the count, so no starve by 29.
    task automatic test_starve();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            arrive = 5'b01000;
            e_q[3] = 1;
            sb.push_back(snap($sformatf("starve%0d_arrive", pass), 5'b0));
            tick();
            arrive = '0;
            e = sb.pop_front();
            checks++;
            if ({q_count, sens_v, depart, total_departed, flags_v} !==
                {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                failures++;
                $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                         e.tag, q_count, sens_v, depart, total_departed, flags_v,
                         e.q, e.sens, e.dep, e.tot, e.flags);
            end
            for (int t = 1; t <= ((pass == 0) ? 21 : 29); t++) begin
                lt[3] = (pass == 1 && t == 10) ? GREEN : RED;
                e_starve[3] = (pass == 0 && t >= 20);
                sb.push_back(snap($sformatf("starve%0d_c%0d", pass, t), 5'b0));
                tick();
                e = sb.pop_front();
                checks++;
                if ({q_count, sens_v, depart, total_departed, flags_v} !==
                    {e.q, e.sens, e.dep, e.tot, e.flags}) begin
                    failures++;
                    $display("FAIL %s: got q=%h sens=%b dep=%b tot=%0d flags=%b, want q=%h sens=%b dep=%b tot=%0d flags=%b",
                             e.tag, q_count, sens_v, depart, total_departed, flags_v,
                             e.q, e.sens, e.dep, e.tot, e.flags);
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        arrive = '0;
        for (int i = 0; i < 5; i++) lt[i] = RED;
        test_reset();
        test_arrival_and_departure();
        test_back_to_back();
        test_overflow();
        test_conflict();
        test_starve();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intersection_traffic_model.md
Name: intersection_traffic_model

Overview:
- Behavioural-synthesizable model of the intersection, driven by traffic_light_controller's lights; drives that controller's sensor inputs.
- Holds a car queue per lane, departs cars on green and raises sensors while a lane's queue is non-empty.
- Also checks light safety and lane starvation.
- Closes the loop so controller benches can run from arrival pulses instead of hand-toggled sensors.
- Lane index order everywhere: 0 e_left, 1 e_str, 2 w_left, 3 w_str, 4 ns.
- Colour encoding: red=2'd0, yellow=2'd1, green=2'd2; 2'd3 is illegal.

Parameters:
QW, 4, queue count width per lane; MAXQ = 2^QW-1 = 15
STARVE_LIM, 20, cycles a non-empty lane may sit at red before its starve bit sets (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
e_left_light  input  2  e-bound left arrow colour
e_str_light  input  2  e-bound straight colour
w_left_light  input  2  w-bound left arrow colour
w_str_light  input  2  w-bound straight colour
ns_light  input  2  n-s colour
arrive  input  5  per-lane one-car arrival pulse, sampled each clk
e_left_sensor  output  1  queue[0] != 0
e_str_sensor  output  1  queue[1] != 0
w_left_sensor  output  1  queue[2] != 0
w_str_sensor  output  1  queue[3] != 0
ns_sensor  output  1  queue[4] != 0
q_count  output  5*QW  flattened queues, lane i at [i*QW +: QW]
depart  output  5  registered one-cycle pulse per departed car
total_departed  output  16  cumulative departures, wraps mod 2^16
overflow  output  1  sticky: arrival dropped at MAXQ
conflict  output  1  sticky: unsafe light combination seen
conflict_code  output  3  rule number of first conflict, 0 if none
bad_color  output  1  sticky: any light input == 2'd3
starve  output  5  sticky per-lane starvation flags

Behaviour:
- Reset (async, immediate): queues 0, sensors 0, depart 0, total_departed 0, all sticky flags 0, conflict_code 0, green_d 0, wait counters 0. Reset mid-operation discards queued cars.
- green_d[i]: registered copy of (light_i == green).
- Departure enable: depart_ok_i = (light_i == green) && green_d[i]. This models a one-cycle reaction, so the first departure is the 2nd green cycle. No departures on yellow or red.
- Per lane each clk: dep = depart_ok_i && q!=0; q_next = q + arrive_i - dep.
- Simultaneous arrive and dep: q unchanged; depart_i still pulses.
- q==MAXQ with arrive and no dep: q holds at MAXQ, overflow <= 1.
- q==0: no departure, no underflow.
- depart[i] is registered dep; it asserts in the same cycle the decremented q is visible.
- Sensors are combinational from registered q, so a sensor rises the cycle after the arrival edge.
- total_departed += popcount(dep) each clk (0..5), modulo 2^16.
- Conflict rules, evaluated each clk on inputs; non-red = colour != red:
  - Rule 1: e_left non-red AND (w_str or ns non-red).
  - Rule 2: w_left non-red AND (e_str or ns non-red).
  - Rule 3: e_str non-red AND ns non-red.
  - Rule 4: w_str non-red AND ns non-red.
- First conflict sets conflict=1 and conflict_code = lowest violated rule number. Both then frozen until reset; later conflicts do not change the code.
- bad_color sets on any light == 3. An illegal colour is treated as non-red for the conflict rules.
- Starvation, per lane wait counter (8-bit):
  - Increments when q!=0 and light==red.
  - Clears when q==0 or light!=red.
  - Saturates at STARVE_LIM.
  - starve[i] <= 1 when the counter reaches STARVE_LIM.

Test Plan:
- Reset, all lights red, arrive=5'b00001 for 3 clks -> q_count lane0=3, e_left_sensor=1 from cycle after first arrival, depart=0, total_departed=0.
- Lane0 q=3, e_left_light green from cycle T -> no depart at T; depart[0] pulses at T+1, T+2, T+3; q=0 and sensor=0 after T+3; total_departed=3.
- Lane4 q=2, ns green, arrive[4] pulsed every green cycle -> q stays at 2 after the reaction cycle, depart[4] pulses each cycle.
- 16 arrivals on lane1 with lights red -> q=15, overflow=1; overflow stays 1 after the queue drains.
- e_str green and ns yellow in the same cycle, later e_left green with ns green -> conflict=1, conflict_code=3, stays 3.
- Lane3 q=1, w_str red for 20 clks -> starve[3]=1 on cycle 20; repeat with a 1-cycle green at cycle 10 -> counter clears, starve[3] stays 0 through cycle 29.
